// File: rtl/dec3to8_hs.sv
// Registered 3-to-8 one-hot decoder with valid/ready handshakes on both sides
// and a walking-one scan sequencer for bring-up and loop-back checks.
module dec3to8_hs #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       scan_start,
  output logic       scan_busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t     state_reg;
  logic [7:0] y_reg;
  logic       out_valid_reg;
  logic       scan_busy_reg;
  logic [2:0] code_reg;
  logic [7:0] hold_reg;

  logic [2:0] in_code;
  logic [2:0] code_inc;
  logic [7:0] in_onehot;
  logic [7:0] scan_onehot_next;
  logic       in_xfer;
  logic       hold_done;
  logic       scan_last;

  assign in_code   = {a, b, c};
  assign code_inc  = code_reg + 3'd1;
  assign hold_done = (hold_reg == 8'(HOLD - 1));
  assign scan_last = (code_reg == 3'd7);

  // Both decoders compare against a constant per output bit, so y can only
  // ever be loaded with a one-hot word (or the explicit zero on reset/exit).
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign in_onehot[gi]        = (in_code == 3'(gi));
      assign scan_onehot_next[gi] = (code_inc == 3'(gi));
    end
  endgenerate

  // A pending scan_start blocks input so it wins over a simultaneous code.
  assign in_ready = !rst && (state_reg == IDLE) && !scan_start &&
                    (!out_valid_reg || out_ready);
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      y_reg         <= 8'h00;
      out_valid_reg <= 1'b0;
      scan_busy_reg <= 1'b0;
      code_reg      <= 3'd0;
      hold_reg      <= 8'd0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (scan_start && !out_valid_reg) begin
            state_reg     <= SCAN;
            scan_busy_reg <= 1'b1;
            y_reg         <= 8'h01;
            code_reg      <= 3'd0;
            hold_reg      <= 8'd0;
          end else if (in_xfer) begin
            y_reg         <= in_onehot;
            out_valid_reg <= 1'b1;
          end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        SCAN: begin
          if (!hold_done) begin
            hold_reg <= hold_reg + 8'd1;
          end else if (scan_last) begin
            state_reg     <= IDLE;
            scan_busy_reg <= 1'b0;
            y_reg         <= 8'h00;
            code_reg      <= 3'd0;
            hold_reg      <= 8'd0;
          end else begin
            hold_reg <= 8'd0;
            code_reg <= code_inc;
            y_reg    <= scan_onehot_next;
          end
        end
        default: begin
          state_reg     <= IDLE;
          scan_busy_reg <= 1'b0;
          y_reg         <= 8'h00;
          out_valid_reg <= 1'b0;
          code_reg      <= 3'd0;
          hold_reg      <= 8'd0;
        end
      endcase
    end
  end

  assign y         = y_reg;
  assign out_valid = out_valid_reg;
  assign scan_busy = scan_busy_reg;

endmodule

// File: tb/tb_dec3to8_hs.sv
// Directed bench for dec3to8_hs: handshake decode, backpressure, scan,
// scan/input priority, ignored scan_start and reset mid-scan.
module tb_dec3to8_hs;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, b, c;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y;
  logic       out_valid;
  logic       out_ready;
  logic       scan_start;
  logic       scan_busy;

  int checks = 0;
  int failures = 0;

  dec3to8_hs #(.HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c         (c),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .scan_start(scan_start),
    .scan_busy (scan_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for checking.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_code(input logic [2:0] code);
    {a, b, c} = code;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_y;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; scan_start = 1'b0;
    set_code(3'd0);
    tick();
    tick();
    check("rst_y", 32'(y), 32'h00);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_scan_busy", 32'(scan_busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back codes 0..7 with downstream always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    exp_y     = 8'h01;
    for (int k = 0; k < 8; k++) begin
      set_code(3'(k));
      tick();
      check($sformatf("b2b_y_%0d", k), 32'(y), 32'(exp_y));
      check($sformatf("b2b_ov_%0d", k), 32'(out_valid), 32'd1);
      exp_y = {exp_y[6:0], 1'b0};
    end
    in_valid = 1'b0;
    tick();
    check("drain_ov", 32'(out_valid), 32'd0);
    check("drain_y_kept", 32'(y), 32'h80);

    // Backpressure: code 5 held while code 2 waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_code(3'd5);
    tick();
    check("bp_y_first", 32'(y), 32'h20);
    set_code(3'd2);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd0);
      tick();
      check($sformatf("bp_y_%0d", k), 32'(y), 32'h20);
      check($sformatf("bp_ov_%0d", k), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_next_y", 32'(y), 32'h04);
    check("bp_next_ov", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    check("bp_drain_ov", 32'(out_valid), 32'd0);

    // Full walking-one scan, HOLD=4.
    scan_start = 1'b1;
    #1;
    check("scan_start_in_ready", 32'(in_ready), 32'd0);
    tick();
    scan_start = 1'b0;
    exp_y = 8'h01;
    for (int k = 0; k < 8; k++) begin
      for (int h = 0; h < 4; h++) begin
        #1;
        check($sformatf("scan_y_%0d_%0d", k, h), 32'(y), 32'(exp_y));
        check($sformatf("scan_busy_%0d_%0d", k, h), 32'(scan_busy), 32'd1);
        check($sformatf("scan_in_ready_%0d_%0d", k, h), 32'(in_ready), 32'd0);
        check($sformatf("scan_ov_%0d_%0d", k, h), 32'(out_valid), 32'd0);
        tick();
      end
      exp_y = {exp_y[6:0], 1'b0};
    end
    check("scan_end_y", 32'(y), 32'h00);
    check("scan_end_busy", 32'(scan_busy), 32'd0);
    check("scan_end_in_ready", 32'(in_ready), 32'd1);

    // scan_start wins over a simultaneous code 3.
    out_ready  = 1'b0;
    scan_start = 1'b1;
    in_valid   = 1'b1;
    set_code(3'd3);
    #1;
    check("prio_in_ready", 32'(in_ready), 32'd0);
    tick();
    scan_start = 1'b0;
    in_valid   = 1'b0;
    check("prio_busy", 32'(scan_busy), 32'd1);
    check("prio_y", 32'(y), 32'h01);
    check("prio_ov", 32'(out_valid), 32'd0);

    // Advance to code 4, then reset mid-scan; scan_start during scan is ignored.
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    check("mid_scan_y", 32'(y), 32'h10);
    check("mid_scan_busy", 32'(scan_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("rst_mid_y", 32'(y), 32'h00);
    check("rst_mid_busy", 32'(scan_busy), 32'd0);
    check("rst_mid_ov", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    set_code(3'd6);
    tick();
    in_valid = 1'b0;
    check("post_rst_y", 32'(y), 32'h40);
    check("post_rst_ov", 32'(out_valid), 32'd1);

    // scan_start ignored while a word is pending and not consumed.
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("ign_busy", 32'(scan_busy), 32'd0);
    check("ign_y", 32'(y), 32'h40);
    check("ign_ov", 32'(out_valid), 32'd1);
    tick();
    check("ign_not_latched", 32'(scan_busy), 32'd0);
    check("ign_y_still", 32'(y), 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
